// File: rtl/gpio_debounce.sv
// Pad input conditioning: two-flop synchronizer, optional per-pin stability
// filter, and registered single-cycle rise/fall pulses for the GPIO block.
module gpio_debounce #(
    parameter int N  = 24,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic [N-1:0]  pad_in,
    input  logic [N-1:0]  cfg_debounce_en,
    input  logic [CW-1:0] cfg_period,
    output logic [N-1:0]  gpio_in,
    output logic [N-1:0]  gpio_rise,
    output logic [N-1:0]  gpio_fall
);

    logic [N-1:0]  s1;
    logic [N-1:0]  s2;
    logic [N-1:0]  next_gpio_in;
    logic [CW-1:0] cnt      [N];
    logic [CW-1:0] next_cnt [N];

    // s1 is the only flop that sees the asynchronous pads; s2 follows it directly.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= pad_in;
            s2 <= s1;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            next_gpio_in[i] = gpio_in[i];
            next_cnt[i]     = '0;
            if (!cfg_debounce_en[i]) begin
                next_gpio_in[i] = s2[i];
            end else if (s2[i] != gpio_in[i]) begin
                // >= so that lowering the period mid-count accepts immediately
                if (cnt[i] >= cfg_period) begin
                    next_gpio_in[i] = s2[i];
                end else begin
                    next_cnt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
            gpio_in   <= '0;
            gpio_rise <= '0;
            gpio_fall <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                cnt[i] <= next_cnt[i];
            end
            gpio_in   <= next_gpio_in;
            gpio_rise <= ~gpio_in & next_gpio_in;
            gpio_fall <= gpio_in & ~next_gpio_in;
        end
    end

endmodule

// File: tb/tb_gpio_debounce.sv
// Bench for gpio_debounce: directed latency/glitch/config cases plus random
// pads compared every cycle against a stability-age reference model.
module tb_gpio_debounce;

    localparam int N  = 24;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic [N-1:0]  pad_in = '0;
    logic [N-1:0]  cfg_debounce_en = '0;
    logic [CW-1:0] cfg_period = '0;
    logic [N-1:0]  gpio_in;
    logic [N-1:0]  gpio_rise;
    logic [N-1:0]  gpio_fall;

    int errors = 0;
    int checks = 0;
    bit mon_on = 1'b0;

    gpio_debounce #(.N(N), .CW(CW)) dut (
        .clk             (clk),
        .nreset          (nreset),
        .pad_in          (pad_in),
        .cfg_debounce_en (cfg_debounce_en),
        .cfg_period      (cfg_period),
        .gpio_in         (gpio_in),
        .gpio_rise       (gpio_rise),
        .gpio_fall       (gpio_fall)
    );

    always #5 clk = ~clk;

    // Reference: a pin's level follows its synchronized value once that value
    // has been seen for P+1 consecutive samples (counted from the later of the
    // last change and the moment the filter was enabled); bypass follows at once.
    logic [N-1:0] m_s1 = '0, m_s2 = '0, m_prev_sy = '0, m_prev_en = '0;
    logic [N-1:0] m_lvl = '0, m_rise = '0, m_fall = '0;
    int           chg_at [N];
    int           en_at  [N];
    int           cyc = 0;

    initial begin
        logic [N-1:0] sy;
        logic [N-1:0] nl;
        int           st;
        for (int i = 0; i < N; i++) begin
            chg_at[i] = 0;
            en_at[i]  = 0;
        end
        forever begin
            @(posedge clk or negedge nreset);
            if (!nreset) begin
                m_s1 = '0; m_s2 = '0; m_prev_sy = '0; m_prev_en = '0;
                m_lvl = '0; m_rise = '0; m_fall = '0;
                cyc = 0;
                for (int i = 0; i < N; i++) begin
                    chg_at[i] = 0;
                    en_at[i]  = 0;
                end
            end else begin
                cyc++;
                sy = m_s2;
                nl = m_lvl;
                for (int i = 0; i < N; i++) begin
                    if (sy[i] != m_prev_sy[i]) chg_at[i] = cyc;
                    if (cfg_debounce_en[i] && !m_prev_en[i]) en_at[i] = cyc;
                    st = cyc - ((chg_at[i] > en_at[i]) ? chg_at[i] : en_at[i]) + 1;
                    if (!cfg_debounce_en[i] || st >= int'(cfg_period) + 1) nl[i] = sy[i];
                end
                m_rise    = ~m_lvl & nl;
                m_fall    = m_lvl & ~nl;
                m_lvl     = nl;
                m_prev_sy = sy;
                m_prev_en = cfg_debounce_en;
                m_s2      = m_s1;
                m_s1      = pad_in;
            end
        end
    end

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_on) begin
                chk("model gpio_in", gpio_in, m_lvl);
                chk("model gpio_rise", gpio_rise, m_rise);
                chk("model gpio_fall", gpio_fall, m_fall);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Drive pad[pin]=target now; optionally restore it after edge flip_at.
    task automatic measure(input int pin, input logic target, input int flip_at, input int maxc,
                           output int at, output int rises, output int falls, output int highs);
        at = -1; rises = 0; falls = 0; highs = 0;
        pad_in[pin] = target;
        for (int k = 1; k <= maxc; k++) begin
            tick();
            if (at < 0 && gpio_in[pin] == target) at = k;
            if (gpio_in[pin] == target) highs++;
            rises += int'(gpio_rise[pin]);
            falls += int'(gpio_fall[pin]);
            if (k == flip_at) pad_in[pin] = ~target;
        end
    endtask

    task automatic settle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int at, rises, falls, highs;
        int nrise, nfall;

        // Reset with pads high, bypass, P=0
        pad_in = '1;
        cfg_debounce_en = '0;
        cfg_period = '0;
        nreset = 1'b0;
        settle(3);
        mon_on = 1'b1;
        chk("reset gpio_in", gpio_in, '0);
        chk("reset gpio_rise", gpio_rise, '0);
        tick();
        nreset = 1'b1;
        tick();
        chk("release edge1 gpio_in", gpio_in, '0);
        tick();
        chk("release edge2 gpio_in", gpio_in, '0);
        tick();
        chk("release edge3 gpio_in", gpio_in, 24'hFFFFFF);
        chk("release edge3 gpio_rise", gpio_rise, 24'hFFFFFF);
        tick();
        chk("release edge4 gpio_rise", gpio_rise, '0);

        pad_in = '0;
        settle(6);

        // Bypass latency on pin 5
        measure(5, 1'b1, 0, 6, at, rises, falls, highs);
        chki("bypass rise latency", at, 3);
        chki("bypass rise pulses", rises, 1);
        pad_in[5] = 1'b0;
        settle(6);
        measure(5, 1'b1, 1, 8, at, rises, falls, highs);
        chki("bypass 1cyc pulse latency", at, 3);
        chki("bypass 1cyc pulse width", highs, 1);
        chki("bypass 1cyc rise", rises, 1);
        chki("bypass 1cyc fall", falls, 1);
        settle(4);

        // Debounce accept, P=10, pin 0
        cfg_period = 16'd10;
        cfg_debounce_en = 24'h000001;
        settle(3);
        measure(0, 1'b1, 0, 20, at, rises, falls, highs);
        chki("debounce rise edge", at, 13);
        chki("debounce rise pulses", rises, 1);
        measure(0, 1'b0, 0, 20, at, rises, falls, highs);
        chki("debounce fall edge", at, 13);
        chki("debounce fall pulses", falls, 1);

        // Glitch reject (10 cycles) and accept (11 cycles)
        measure(0, 1'b1, 10, 30, at, rises, falls, highs);
        chki("glitch10 accepted edge", at, -1);
        chki("glitch10 rises", rises, 0);
        chki("glitch10 falls", falls, 0);
        measure(0, 1'b1, 11, 30, at, rises, falls, highs);
        chki("glitch11 accepted edge", at, 13);
        chki("glitch11 rises", rises, 1);
        chki("glitch11 falls", falls, 1);
        pad_in[0] = 1'b0;
        settle(5);

        // Lower the period while a count is in progress
        cfg_period = 16'd100;
        settle(2);
        pad_in[0] = 1'b1;
        settle(52);
        chk("cfgchg before gpio_in0", {23'd0, gpio_in[0]}, '0);
        cfg_period = 16'd20;
        tick();
        chk("cfgchg after gpio_in0", {23'd0, gpio_in[0]}, 24'd1);
        chk("cfgchg after rise0", {23'd0, gpio_rise[0]}, 24'd1);
        pad_in = '0;
        cfg_period = '0;
        settle(6);

        // Random pads, mixed enables, P=3 (with occasional config churn)
        cfg_period = 16'd3;
        cfg_debounce_en = N'($urandom);
        for (int c = 0; c < 1800; c++) begin
            pad_in = pad_in ^ (N'($urandom) & N'($urandom) & N'($urandom));
            if (c % 300 == 299) cfg_debounce_en = N'($urandom);
            if (c == 900) cfg_period = 16'($urandom_range(0, 5));
            if (c == 1200) cfg_period = 16'd3;
            tick();
        end

        // Async reset mid-count: levels partly high, counts running elsewhere
        cfg_debounce_en = '0;
        pad_in = 24'h0F0F0F;
        settle(6);
        chk("prereset levels", gpio_in, 24'h0F0F0F);
        cfg_debounce_en = '1;
        cfg_period = 16'd20;
        pad_in = 24'hF0F0F0;
        settle(8);
        pad_in = '0;
        nreset = 1'b0;
        #1;
        chk("async reset gpio_in", gpio_in, '0);
        chk("async reset gpio_rise", gpio_rise, '0);
        chk("async reset gpio_fall", gpio_fall, '0);
        settle(2);
        nreset = 1'b1;
        nrise = 0;
        nfall = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (gpio_rise != '0) nrise++;
            if (gpio_fall != '0) nfall++;
        end
        chki("post reset rise cycles", nrise, 0);
        chki("post reset fall cycles", nfall, 0);
        chk("post reset gpio_in", gpio_in, '0);

        mon_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
